dnn_run_seq: RTL and testbench
==============================

# dnn_run_seq

Run sequencer for the on-board DNN datapath. Holds the DNN in reset until DDR calibration completes and the weight/input FIFO reaches its fill threshold, then drives the DNN reset pulse, the clock-gate enable, the FIFO read strobe and the input-zero select. It captures one output activation per DNN cycle into an external result store and stops after a fixed number of outputs. It replaces the ad-hoc reset/begin/stop logic in the board top level and adds FIFO-underrun stalling and re-run on request.

## Interface
Parameters:
- RST_CYCLES, 4: DNN reset pulse length in clk cycles (≥1)
- FILL_LEVEL, 49: FIFO write count required before a run starts
- NUM_OUT, 200: outputs captured per run (≤ 2^ADDR_W)
- CYC_FIRST, 2: first cycle_index with valid FIFO input
- CYC_LAST, 50: last cycle_index with valid FIFO input
- OUT_W, 10: captured activation width
- ADDR_W, 8: result-store address width

Ports:
- clk  in  1  free-running 10 MHz clock, ungated source of the DNN gated clock
- resetn  in  1  reset, asynchronous, active-low
- calib_done_i  in  1  DDR init_calib_complete
- start_i  in  1  one-cycle re-run request, honoured only in DONE
- fifo_wr_count_i  in  7  FIFO write-side data count
- fifo_empty_i  in  1  FIFO empty
- cycle_index_i  in  7  DNN cycle index
- cycle_clk_i  in  1  DNN end-of-cycle strobe
- act_i  in  OUT_W  DNN output activation bits
- gate_en_o  out  1  CE for the DNN clock BUFGCE
- dnn_rst_o  out  1  DNN synchronous reset
- fifo_rd_o  out  1  FIFO read enable
- input_zero_o  out  1  1 selects zero as the DNN input instead of fifo_out
- store_we_o, store_addr_o[ADDR_W], store_data_o[OUT_W]  out  result-store write port
- busy_o  out  1  state is RST or RUN
- done_o  out  1  state is DONE
- stall_o  out  1  RUN stalled on empty FIFO
- stall_cnt_o  out  16  saturating count of stalled cycles

## Operation
- States: IDLE, FILL, RST, RUN, DONE. Reset enters IDLE.
- IDLE: transitions to FILL when calib_done_i=1.
- FILL: transitions to RST when fifo_wr_count_i ≥ FILL_LEVEL.
- RST: dnn_rst_o=1 and gate_en_o=1 for exactly RST_CYCLES cycles, then RUN. On entry, clears out_cnt and stall_cnt_o.
- RUN:
  - window = CYC_FIRST ≤ cycle_index_i ≤ CYC_LAST
  - input_zero_o = ~window
  - stall_o = window & fifo_empty_i
  - fifo_rd_o = window & ~fifo_empty_i
  - gate_en_o = ~stall_o. The DNN freezes while stalled; a stall never drops input data.
- Capture: on a clk edge in RUN with gate_en_o=1 and cycle_clk_i=1, the block registers act_i into store_data_o and out_cnt into store_addr_o, pulses store_we_o on the next cycle, and increments out_cnt. The write with out_cnt = NUM_OUT−1 moves the FSM to DONE. cycle_clk_i is ignored in every other case.
- DONE: gate_en_o=0 and dnn_rst_o=0. start_i moves the FSM to FILL.
- calib_done_i=0 in any state moves the FSM to IDLE next cycle. It does not cancel a pending store write.
- Outside RUN: fifo_rd_o=0, input_zero_o=1, stall_o=0.
- stall_cnt_o increments on each RUN cycle with stall_o=1 and saturates at 0xFFFF.

## Timing
- Reset values: gate_en_o=0, dnn_rst_o=0, fifo_rd_o=0, input_zero_o=1, store_we_o=0, store_addr_o=0, store_data_o=0, busy_o=0, done_o=0, stall_o=0, stall_cnt_o=0.
- fifo_rd_o, input_zero_o, stall_o and gate_en_o are combinational from the registered state and current inputs. They are glitch-free relative to the clk edge because their inputs are synchronous to clk.
- dnn_rst_o is registered: high on the first cycle after entering RST, low on the first RUN cycle.
- FILL→RST takes 1 cycle after the threshold condition is sampled.
- Capture latency is 1 cycle, cycle_clk_i edge to store_we_o.
- DONE is entered the cycle after the final capture edge. The final store_we_o coincides with done_o rising.
- When stall and cycle_clk_i coincide, no capture occurs; the strobe is held until gate_en_o returns.
- start_i outside DONE has no effect.

## Test plan
- Nominal run: NUM_OUT=200, FIFO pre-filled to 49, calib high → dnn_rst_o high for 4 cycles; 200 store_we_o pulses with addresses 0..199 in order; done_o=1; gate_en_o=0 afterwards.
- Fill gating: calib high with fifo_wr_count_i=48 for 100 cycles → stays in FILL with gate_en_o=0; set count to 49 → RST begins 1 cycle later.
- Window: cycle_index_i swept 0..63 in RUN → fifo_rd_o=1 and input_zero_o=0 only for indices 2..50.
- Underrun: fifo_empty_i=1 for 5 cycles at cycle_index_i=10 → stall_o=1 and gate_en_o=0 for 5 cycles, stall_cnt_o=5, no capture lost (200 writes total).
- Re-run: after DONE, pulse start_i → FILL, then RST, and store_addr_o restarts at 0. A start_i pulse during RUN is ignored.
- Abort: drop calib_done_i mid-RUN at output 57 → IDLE next cycle with gate_en_o=0 and busy_o=0. Assert resetn low mid-RUN → all outputs at their reset values immediately.

Source files
------------

// File: rtl/dnn_run_seq.sv
// dnn_run_seq: run sequencer for the on-board DNN datapath.
// Holds the DNN off until DDR calibration and FIFO fill, pulses DNN reset,
// gates the DNN clock around FIFO underruns, and streams NUM_OUT activations
// into an external result store.
module dnn_run_seq #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned FILL_LEVEL = 49,
  parameter int unsigned NUM_OUT    = 200,
  parameter int unsigned CYC_FIRST  = 2,
  parameter int unsigned CYC_LAST   = 50,
  parameter int unsigned OUT_W      = 10,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              calib_done_i,
  input  logic              start_i,
  input  logic [6:0]        fifo_wr_count_i,
  input  logic              fifo_empty_i,
  input  logic [6:0]        cycle_index_i,
  input  logic              cycle_clk_i,
  input  logic [OUT_W-1:0]  act_i,
  output logic              gate_en_o,
  output logic              dnn_rst_o,
  output logic              fifo_rd_o,
  output logic              input_zero_o,
  output logic              store_we_o,
  output logic [ADDR_W-1:0] store_addr_o,
  output logic [OUT_W-1:0]  store_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              stall_o,
  output logic [15:0]       stall_cnt_o
);

  localparam int unsigned CNT_W = 7;
  localparam int unsigned SC_W  = 16;
  localparam int unsigned RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_RST  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [ADDR_W-1:0]   out_cnt_q, out_cnt_d;
  logic [SC_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic                store_we_q, store_we_d;
  logic [ADDR_W-1:0]   store_addr_q, store_addr_d;
  logic [OUT_W-1:0]    store_data_q, store_data_d;
  logic                dnn_rst_q, dnn_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                run_c;
  logic                win_c;
  logic                stall_c;
  logic                capture_c;

  // Input-window decode and DNN-side strobes from the registered state
  always_comb begin
    run_c     = (state_q == S_RUN);
    win_c     = (cycle_index_i >= CNT_W'(CYC_FIRST)) &&
                (cycle_index_i <= CNT_W'(CYC_LAST));
    stall_c   = run_c & win_c & fifo_empty_i;
    capture_c = run_c & ~stall_c & cycle_clk_i;
  end

  // Next-state, counters and result-store capture
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    out_cnt_d    = out_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    store_we_d   = 1'b0;
    store_addr_d = store_addr_q;
    store_data_d = store_data_q;

    if (capture_c) begin
      store_we_d   = 1'b1;
      store_addr_d = out_cnt_q;
      store_data_d = act_i;
      out_cnt_d    = out_cnt_q + ADDR_W'(1);
    end

    if (stall_c && (stall_cnt_q != {SC_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + SC_W'(1);
    end

    case (state_q)
      S_IDLE: state_d = S_FILL;
      S_FILL: begin
        if (fifo_wr_count_i >= CNT_W'(FILL_LEVEL)) begin
          state_d     = S_RST;
          rst_cnt_d   = '0;
          out_cnt_d   = '0;
          stall_cnt_d = '0;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      S_RUN: begin
        if (capture_c && (out_cnt_q == ADDR_W'(NUM_OUT - 1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start_i) begin
          state_d = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Losing calibration aborts from anywhere; an in-flight store write still completes
    if (!calib_done_i) begin
      state_d = S_IDLE;
    end

    dnn_rst_d = (state_d == S_RST);
    busy_d    = (state_d == S_RST) || (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      out_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      store_we_q   <= 1'b0;
      store_addr_q <= '0;
      store_data_q <= '0;
      dnn_rst_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      out_cnt_q    <= out_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      store_we_q   <= store_we_d;
      store_addr_q <= store_addr_d;
      store_data_q <= store_data_d;
      dnn_rst_q    <= dnn_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign gate_en_o    = (state_q == S_RST) | (run_c & ~stall_c);
  assign fifo_rd_o    = run_c & win_c & ~fifo_empty_i;
  assign input_zero_o = ~(run_c & win_c);
  assign stall_o      = stall_c;
  assign dnn_rst_o    = dnn_rst_q;
  assign store_we_o   = store_we_q;
  assign store_addr_o = store_addr_q;
  assign store_data_o = store_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_dnn_run_seq.sv
// Testbench for dnn_run_seq: random DNN/FIFO traffic against a behavioural
// run model, with a scoreboard queue of expected result-store writes.
module tb_dnn_run_seq;

  localparam int RST_CYCLES = 4;
  localparam int FILL_LEVEL = 49;
  localparam int NUM_OUT    = 200;
  localparam int CYC_FIRST  = 2;
  localparam int CYC_LAST   = 50;
  localparam int OUT_W      = 10;
  localparam int ADDR_W     = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              calib_done_i = 1'b0;
  logic              start_i = 1'b0;
  logic [6:0]        fifo_wr_count_i = '0;
  logic              fifo_empty_i = 1'b1;
  logic [6:0]        cycle_index_i = '0;
  logic              cycle_clk_i = 1'b0;
  logic [OUT_W-1:0]  act_i = '0;
  logic              gate_en_o, dnn_rst_o, fifo_rd_o, input_zero_o, store_we_o;
  logic [ADDR_W-1:0] store_addr_o;
  logic [OUT_W-1:0]  store_data_o;
  logic              busy_o, done_o, stall_o;
  logic [15:0]       stall_cnt_o;

  dnn_run_seq #(
    .RST_CYCLES(RST_CYCLES), .FILL_LEVEL(FILL_LEVEL), .NUM_OUT(NUM_OUT),
    .CYC_FIRST(CYC_FIRST), .CYC_LAST(CYC_LAST), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .resetn(resetn), .calib_done_i(calib_done_i), .start_i(start_i),
    .fifo_wr_count_i(fifo_wr_count_i), .fifo_empty_i(fifo_empty_i),
    .cycle_index_i(cycle_index_i), .cycle_clk_i(cycle_clk_i), .act_i(act_i),
    .gate_en_o(gate_en_o), .dnn_rst_o(dnn_rst_o), .fifo_rd_o(fifo_rd_o),
    .input_zero_o(input_zero_o), .store_we_o(store_we_o), .store_addr_o(store_addr_o),
    .store_data_o(store_data_o), .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wr_seen = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural run model ----------------
  typedef enum int {P_IDLE, P_FILL, P_RST, P_RUN, P_DONE} ph_t;
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [OUT_W-1:0]  d;
  } wr_t;

  ph_t  m_ph = P_IDLE;
  int   m_rst_left = 0;
  int   m_cnt = 0;
  int   m_stall = 0;
  bit   m_we = 1'b0;
  bit   m_stl, m_cap, m_last;
  wr_t  exp_q[$];

  function automatic bit in_win(input logic [6:0] ci);
    return (int'(ci) >= CYC_FIRST) && (int'(ci) <= CYC_LAST);
  endfunction

  function bit e_stall();
    return (m_ph == P_RUN) && in_win(cycle_index_i) && fifo_empty_i;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ph = P_IDLE; m_cnt = 0; m_stall = 0; m_we = 1'b0; m_rst_left = 0;
      exp_q.delete();
    end else begin
      m_stl  = e_stall();
      m_cap  = (m_ph == P_RUN) && !m_stl && cycle_clk_i;
      m_we   = m_cap;
      m_last = 1'b0;
      if (m_cap) begin
        exp_q.push_back({ADDR_W'(m_cnt), act_i});
        m_last = (m_cnt == NUM_OUT - 1);
        m_cnt++;
      end
      if (m_stl && m_stall < 65535) m_stall++;
      if (!calib_done_i) m_ph = P_IDLE;
      else begin
        case (m_ph)
          P_IDLE: m_ph = P_FILL;
          P_FILL: if (int'(fifo_wr_count_i) >= FILL_LEVEL) begin
            m_ph = P_RST; m_rst_left = RST_CYCLES; m_cnt = 0; m_stall = 0;
          end
          P_RST: begin
            m_rst_left--;
            if (m_rst_left == 0) m_ph = P_RUN;
          end
          P_RUN:  if (m_last) m_ph = P_DONE;
          P_DONE: if (start_i) m_ph = P_FILL;
          default: m_ph = P_IDLE;
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] got_v, exp_v;
  bit         es;
  wr_t        ew;
  initial begin
    forever begin
      @(posedge clk);
      #8;
      es    = e_stall();
      got_v = {gate_en_o, dnn_rst_o, fifo_rd_o, input_zero_o, store_we_o, busy_o, done_o, stall_o};
      exp_v = {(m_ph == P_RST) || ((m_ph == P_RUN) && !es),
               m_ph == P_RST,
               (m_ph == P_RUN) && in_win(cycle_index_i) && !fifo_empty_i,
               !((m_ph == P_RUN) && in_win(cycle_index_i)),
               m_we,
               (m_ph == P_RST) || (m_ph == P_RUN),
               m_ph == P_DONE,
               es};
      chk("outs{gate,rst,rd,zero,we,busy,done,stall}", 32'(got_v), 32'(exp_v));
      chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
      if (m_we) begin
        if (exp_q.size() == 0) chk("wr_queue_empty", 32'd1, 32'd0);
        else begin
          ew = exp_q.pop_front();
          if (store_we_o) begin
            chk("wr_addr", 32'(store_addr_o), 32'(ew.a));
            chk("wr_data", 32'(store_data_o), 32'(ew.d));
          end
        end
      end
      if (store_we_o) wr_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic rand_dnn(input int empty_pct);
    cycle_index_i = 7'($urandom_range(0, 63));
    cycle_clk_i   = 1'($urandom_range(0, 1));
    fifo_empty_i  = ($urandom_range(0, 99) < empty_pct);
    act_i         = OUT_W'($urandom);
    start_i       = 1'b0;
  endtask

  task automatic quiet();
    cycle_clk_i = 1'b0; fifo_empty_i = 1'b0; start_i = 1'b0; cycle_index_i = '0;
  endtask

  task automatic run_to_done(input int empty_pct, input string tag);
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done_o) break;
      rand_dnn(empty_pct);
    end
    chk({tag, "_done_reached"}, 32'(done_o), 32'd1);
    quiet();
    repeat (3) @(negedge clk);
    chk({tag, "_writes"}, 32'(wr_seen), 32'(NUM_OUT));
    chk({tag, "_gate_after_done"}, 32'(gate_en_o), 32'd0);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({gate_en_o, dnn_rst_o, fifo_rd_o, input_zero_o, store_we_o,
                           busy_o, done_o, stall_o}), 32'h10);
    chk("reset_addr", 32'(store_addr_o), 32'd0);
    chk("reset_data", 32'(store_data_o), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);
    resetn = 1'b1;

    // Fill gating: one short of the threshold holds in FILL
    calib_done_i = 1'b1;
    fifo_wr_count_i = 7'(FILL_LEVEL - 1);
    repeat (100) begin
      @(negedge clk);
      rand_dnn(0);
      start_i = 1'($urandom_range(0, 1));
    end
    chk("fill_hold_gate", 32'(gate_en_o), 32'd0);
    chk("fill_hold_busy", 32'(busy_o), 32'd0);
    quiet();
    wr_seen = 0;
    fifo_wr_count_i = 7'(FILL_LEVEL);
    @(negedge clk);
    chk("rst_begin", 32'(dnn_rst_o), 32'd1);
    repeat (RST_CYCLES - 1) @(negedge clk);
    chk("rst_last_cycle", 32'(dnn_rst_o), 32'd1);
    @(negedge clk);
    chk("rst_end_in_run", 32'({dnn_rst_o, busy_o}), 32'b01);

    // Window sweep with data available and no strobe
    for (int i = 0; i < 64; i++) begin
      cycle_index_i = 7'(i);
      #1;
      chk("win_fifo_rd", 32'(fifo_rd_o), 32'((i >= 2) && (i <= 50)));
      chk("win_input_zero", 32'(input_zero_o), 32'(!((i >= 2) && (i <= 50))));
      @(negedge clk);
    end

    // Underrun: 5 cycles of empty FIFO with a held strobe at index 10
    cycle_index_i = 7'd10; fifo_empty_i = 1'b1; cycle_clk_i = 1'b1; act_i = OUT_W'(10'h2A5);
    #1;
    chk("underrun_gate", 32'({gate_en_o, stall_o}), 32'b01);
    repeat (5) @(negedge clk);
    chk("underrun_stall_cnt", 32'(stall_cnt_o), 32'd5);
    fifo_empty_i = 1'b0;
    @(negedge clk);
    cycle_clk_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    run_to_done(5, "run1");

    // Re-run after DONE
    wr_seen = 0;
    pulse_start();
    run_to_done(10, "run2");

    // Abort by calibration loss at output 57
    wr_seen = 0;
    pulse_start();
    for (int k = 0; k < 3000 && wr_seen < 57; k++) begin
      @(negedge clk);
      if (wr_seen < 57) rand_dnn(5);
    end
    chk("abort_reached_57", 32'(wr_seen >= 57), 32'd1);
    calib_done_i = 1'b0;
    quiet();
    @(negedge clk);
    @(negedge clk);
    chk("abort_idle", 32'({gate_en_o, busy_o, done_o}), 32'd0);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-run
    calib_done_i = 1'b1;
    repeat (RST_CYCLES + 3) @(negedge clk);
    chk("rerun_busy", 32'(busy_o), 32'd1);
    repeat (30) begin
      @(negedge clk);
      rand_dnn(5);
      cycle_clk_i = 1'b1;
    end
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_outs", 32'({gate_en_o, dnn_rst_o, fifo_rd_o, input_zero_o, store_we_o,
                                 busy_o, done_o, stall_o}), 32'h10);
    chk("async_reset_addr", 32'(store_addr_o), 32'd0);
    chk("async_reset_data", 32'(store_data_o), 32'd0);
    chk("async_reset_stall_cnt", 32'(stall_cnt_o), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    quiet();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
